// File: rtl/instr_mem_responder_pkg.sv
// Shared types and constants for the instruction-fetch responder.
package instr_mem_responder_pkg;

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/instr_resp_pipe.sv
// RESP_LAT-stage valid/data/err delay line; RESP_LAT=0 passes straight through.
module instr_resp_pipe #(
  parameter int unsigned RESP_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_err,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_err
);

  generate
    if (RESP_LAT == 0) begin : g_wire
      assign out_valid = in_valid;
      assign out_data  = in_data;
      assign out_err   = in_err;
    end else begin : g_regs
      logic [RESP_LAT-1:0]       valid_q;
      logic [RESP_LAT-1:0]       err_q;
      logic [RESP_LAT-1:0][31:0] data_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= '0;
          err_q   <= '0;
          data_q  <= '0;
        end else begin
          valid_q[0] <= in_valid;
          err_q[0]   <= in_err;
          data_q[0]  <= in_data;
          for (int unsigned i = 1; i < RESP_LAT; i++) begin
            valid_q[i] <= valid_q[i-1];
            err_q[i]   <= err_q[i-1];
            data_q[i]  <= data_q[i-1];
          end
        end
      end

      assign out_valid = valid_q[RESP_LAT-1];
      assign out_data  = data_q[RESP_LAT-1];
      assign out_err   = err_q[RESP_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch req/gnt/rvalid responder in front of a sync-read SRAM.
// Optional out-of-window error responses: define INSTR_MEM_RESPONDER_ERR_EN.
module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned GNT_WAIT  = 0,
  parameter int unsigned RESP_LAT  = 0,
  localparam int unsigned AW       = clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_req_i,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  output logic          instr_err_o,
  output logic          mem_req_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic [31:0]   mem_rdata_i
);

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          gnt;
  logic [AW-1:0] word_idx;
  logic [AW-1:0] mem_addr_q;
  logic          resp_valid_q;
  logic          stage_err;
  logic [31:0]   stage_data;
  logic          pipe_valid;
  logic [31:0]   pipe_data;
  logic          pipe_err;
  logic [31:0]   rdata_hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_req_i) begin
          if (GNT_WAIT == 0) begin
            gnt = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 32'd1;
          end
        end
      end
      WAIT: begin
        if (!instr_req_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == GNT_WAIT) begin
          gnt     = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign word_idx    = AW'((instr_addr_i - BASE_ADDR) >> 2);
  assign instr_gnt_o = gnt;

`ifdef INSTR_MEM_RESPONDER_ERR_EN
  localparam logic [32:0] WIN_BYTES = 33'(MEM_WORDS) << 2;
  logic in_range;
  logic resp_err_q;

  assign in_range  = (instr_addr_i >= BASE_ADDR) &&
                     ({1'b0, instr_addr_i - BASE_ADDR} < WIN_BYTES);
  assign mem_req_o = gnt & in_range;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) resp_err_q <= 1'b0;
    else        resp_err_q <= gnt & ~in_range;
  end

  // No SRAM read was issued for an errored request, so its data is forced.
  assign stage_err  = resp_err_q;
  assign stage_data = resp_err_q ? ERR_RDATA : mem_rdata_i;
`else
  assign mem_req_o  = gnt;
  assign stage_err  = 1'b0;
  assign stage_data = mem_rdata_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q   <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      resp_valid_q <= gnt;
      if (gnt) mem_addr_q <= word_idx;
    end
  end

  assign mem_addr_o = gnt ? word_idx : mem_addr_q;

  instr_resp_pipe #(
    .RESP_LAT (RESP_LAT)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (resp_valid_q),
    .in_data   (stage_data),
    .in_err    (stage_err),
    .out_valid (pipe_valid),
    .out_data  (pipe_data),
    .out_err   (pipe_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rdata_hold_q <= '0;
    else if (pipe_valid) rdata_hold_q <= pipe_data;
  end

  assign instr_rvalid_o = pipe_valid;
  assign instr_rdata_o  = pipe_valid ? pipe_data : rdata_hold_q;
  assign instr_err_o    = pipe_valid & pipe_err;

endmodule
